zxw_div: RTL and testbench
==========================

ZXW_DIV -- requirements
Module: zxw_div

Interface
REQ-001 Parameter: N, default 4, operand width; only N=4 is supported, and it matches the 4-bit add/sub unit.
REQ-002 Clock  input  1  single clock; all state updates on its rising edge.
REQ-003 Resetn  input  1  asynchronous, active-low reset.
REQ-004 Start  input  1  request pulse; sampled only in IDLE.
REQ-005 Dividend  input  4  unsigned dividend; captured on an accepted Start.
REQ-006 Divisor  input  4  unsigned divisor; captured on an accepted Start.
REQ-007 Busy  output  1  high in CALC and DONE states.
REQ-008 Done  output  1  one-cycle pulse when results become valid.
REQ-009 Quotient  output  4  unsigned quotient.
REQ-010 Remainder  output  4  unsigned remainder.
REQ-011 DivZero  output  1  set when the captured Divisor was 0.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, CALC, DONE.
REQ-013 IDLE: Start=1 captures Dividend into A, Divisor into D, clears R and sets the iteration count to 3.
  - If Divisor != 0: go to CALC and clear DivZero.
  - If Divisor == 0: go to DONE.
REQ-014 CALC performs one restoring step per cycle, MSB first.
  - Trial operand T = {R[2:0], A[3]}.
  - The add/sub unit computes T - D (Cin=1, x=T, y=D).
  - Cout=1 means no borrow.
REQ-015 The step succeeds when Cout=1 or R[3]=1 (5-bit shifted value >= 16 > D).
  - Success: R <= difference[3:0], and A <= {A[2:0], 1}.
  - Failure: R <= T, and A <= {A[2:0], 0}.
REQ-016 After the step with count=0, the FSM goes to DONE; otherwise the count decrements.
  - CALC occupies exactly 4 cycles.
REQ-017 DONE lasts one cycle with Done=1, then the FSM returns to IDLE.
  - Latency: Start accepted at edge k gives Done high in cycle k+5 (k+1 for divide-by-zero).
REQ-018 Normal completion: Quotient=A and Remainder=R, valid from the DONE cycle.
REQ-019 Divide-by-zero: Quotient=4'b1111, Remainder=captured Dividend, DivZero=1, set on entry to DONE.
REQ-020 Quotient, Remainder and DivZero SHALL hold their values in IDLE until the next accepted Start.
  - During CALC they SHALL keep the previous result.
  - Expose results from shadow registers, updated only on entry to DONE.
REQ-021 Start while Busy=1 SHALL be ignored, with no capture and no restart.
REQ-022 Start in the DONE cycle is ignored.
  - Start held high into the following IDLE cycle is accepted there, giving back-to-back operation with one IDLE cycle between jobs.
REQ-023 Dividend/Divisor changes after capture SHALL NOT affect the operation in progress.
REQ-024 Invariant on normal completion: Quotient*Divisor + Remainder == Dividend, and Remainder < Divisor.

Reset
REQ-025 Resetn=0 SHALL immediately force the following, independent of Clock:
  - state IDLE;
  - A, R, D and count to 0;
  - Quotient, Remainder to 0;
  - Busy, Done, DivZero to 0.
REQ-026 Reset asserted mid-CALC SHALL abort the operation with no Done pulse.
  - The first Start after release is handled as from power-up.

Structure
REQ-027 A shared package SHALL hold:
  - the operand width constant (4);
  - the state enumeration IDLE/CALC/DONE;
  - the iteration-count width (2 bits).
REQ-028 The subtract step SHALL use exactly one instance of the existing 4-bit adder/subtractor zxw_far.
  - Cin is tied to 1 (subtract mode).
  - No other arithmetic operators are used in the datapath.
REQ-029 The FSM and registers live in zxw_div; no other sub-modules.

Verification
REQ-030 Normal case: Dividend=13, Divisor=4, pulse Start.
  - Exactly 5 cycles later: Done=1, Quotient=3, Remainder=1, DivZero=0.
REQ-031 Corner values:
  - 15/1 gives Q=15, R=0.
  - 5/7 gives Q=0, R=5.
  - 15/15 gives Q=1, R=0.
  - 0/9 gives Q=0, R=0.
  - 8/3 gives Q=2, R=2.
REQ-032 Divide-by-zero: Dividend=9, Divisor=0, Start.
  - Next cycle: Done=1, DivZero=1, Quotient=15, Remainder=9, Busy high for one cycle only.
REQ-033 Ignored Start: start 12/5, pulse Start again with 15/1 in cycle 2 of CALC, and change the inputs.
  - Result Q=2, R=2; exactly one Done pulse.
REQ-034 Reset mid-operation: assert Resetn=0 in cycle 3 of CALC, asynchronously to Clock.
  - Outputs go to 0 at once, with no Done.
  - After release, 10/3 gives Q=3, R=1.
REQ-035 Exhaustive self-check: all 256 Dividend/Divisor pairs back-to-back.
  - The bench checks REQ-024 for every Divisor != 0 and REQ-019 for Divisor = 0.
  - On any mismatch it reports the failing pair and stops; otherwise it prints pass and finishes.

Source files
------------

// File: rtl/zxw_div_pkg.sv
// rtl/zxw_div_pkg.sv - shared widths, state encoding and helpers for the restoring divider
package zxw_div_pkg;

  localparam int unsigned OP_W  = 4;
  localparam int unsigned CNT_W = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  // Iteration count step-down as a lookup so the datapath carries no extra subtractor.
  function automatic logic [CNT_W-1:0] cnt_dec(input logic [CNT_W-1:0] c);
    logic [CNT_W-1:0] r;
    r = '0;
    unique case (c)
      2'd3:    r = 2'd2;
      2'd2:    r = 2'd1;
      2'd1:    r = 2'd0;
      default: r = 2'd0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/zxw_far.sv
// rtl/zxw_far.sv - 4-bit ripple adder/subtractor
// cin=1 selects subtract (x + ~y + 1); cout=1 then means no borrow.
module zxw_far (
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  logic [3:0] y_eff;
  logic [4:0] c;

  always_comb begin
    y_eff = y ^ {4{cin}};
    c     = '0;
    s     = '0;
    c[0]  = cin;
    for (int i = 0; i < 4; i++) begin
      s[i]   = x[i] ^ y_eff[i] ^ c[i];
      c[i+1] = (x[i] & y_eff[i]) | (c[i] & (x[i] ^ y_eff[i]));
    end
    cout = c[4];
  end

endmodule

// File: rtl/zxw_div.sv
// rtl/zxw_div.sv - 4-bit unsigned restoring divider, one quotient bit per cycle
// Results are shadowed and only change on entry to DONE.
module zxw_div
  import zxw_div_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         Clock,
  input  logic         Resetn,
  input  logic         Start,
  input  logic [N-1:0] Dividend,
  input  logic [N-1:0] Divisor,
  output logic         Busy,
  output logic         Done,
  output logic [N-1:0] Quotient,
  output logic [N-1:0] Remainder,
  output logic         DivZero
);

  state_e             state_q, state_d;
  logic [N-1:0]       a_q, a_d;
  logic [N-1:0]       r_q, r_d;
  logic [N-1:0]       d_q, d_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [N-1:0]       quo_q, quo_d;
  logic [N-1:0]       rem_q, rem_d;
  logic               dz_q, dz_d;

  logic [N-1:0]       trial;
  logic [N-1:0]       diff;
  logic               no_borrow;
  logic               step_ok;
  logic               div_is_zero;

  assign trial       = {r_q[N-2:0], a_q[N-1]};
  assign div_is_zero = ~|Divisor;

  zxw_far u_far (
    .x    (trial),
    .y    (d_q),
    .cin  (1'b1),
    .s    (diff),
    .cout (no_borrow)
  );

  // r_q[3] set means the shifted partial remainder is >= 16, which always exceeds D.
  assign step_ok = no_borrow | r_q[N-1];

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (Start) state_d = div_is_zero ? DONE : CALC;
      CALC:    if (cnt_q == '0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    Busy = (state_q != IDLE);
    Done = (state_q == DONE);
  end

  always_comb begin
    a_d   = a_q;
    r_d   = r_q;
    d_d   = d_q;
    cnt_d = cnt_q;
    quo_d = quo_q;
    rem_d = rem_q;
    dz_d  = dz_q;
    unique case (state_q)
      IDLE: begin
        if (Start) begin
          a_d   = Dividend;
          d_d   = Divisor;
          r_d   = '0;
          cnt_d = {CNT_W{1'b1}};
          if (div_is_zero) begin
            quo_d = {N{1'b1}};
            rem_d = Dividend;
            dz_d  = 1'b1;
          end else begin
            dz_d  = 1'b0;
          end
        end
      end
      CALC: begin
        r_d   = step_ok ? diff : trial;
        a_d   = {a_q[N-2:0], step_ok};
        cnt_d = cnt_dec(cnt_q);
        if (cnt_q == '0) begin
          quo_d = a_d;
          rem_d = r_d;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      a_q   <= '0;
      r_q   <= '0;
      d_q   <= '0;
      cnt_q <= '0;
      quo_q <= '0;
      rem_q <= '0;
      dz_q  <= 1'b0;
    end else begin
      a_q   <= a_d;
      r_q   <= r_d;
      d_q   <= d_d;
      cnt_q <= cnt_d;
      quo_q <= quo_d;
      rem_q <= rem_d;
      dz_q  <= dz_d;
    end
  end

  assign Quotient  = quo_q;
  assign Remainder = rem_q;
  assign DivZero   = dz_q;

endmodule

// File: tb/tb_zxw_div.sv
// tb/tb_zxw_div.sv - self-checking bench for zxw_div
module tb_zxw_div;

  logic       Clock = 1'b0;
  logic       Resetn = 1'b0;
  logic       Start = 1'b0;
  logic [3:0] Dividend = '0;
  logic [3:0] Divisor = '0;
  logic       Busy, Done, DivZero;
  logic [3:0] Quotient, Remainder;

  int checks = 0;
  int failures = 0;

  zxw_div #(.N(4)) dut (
    .Clock     (Clock),
    .Resetn    (Resetn),
    .Start     (Start),
    .Dividend  (Dividend),
    .Divisor   (Divisor),
    .Busy      (Busy),
    .Done      (Done),
    .Quotient  (Quotient),
    .Remainder (Remainder),
    .DivZero   (DivZero)
  );

  always #5 Clock = ~Clock;

  // Reference: a job is a countdown of cycles, results come from / and %.
  int         m_left;
  logic       m_busy, m_done, m_dz;
  logic [3:0] m_q, m_r, m_pq, m_pr;

  always @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      m_left <= 0;
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_dz   <= 1'b0;
      m_q    <= '0;
      m_r    <= '0;
      m_pq   <= '0;
      m_pr   <= '0;
    end else if (m_done) begin
      m_done <= 1'b0;
      m_busy <= 1'b0;
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_done <= 1'b1;
        m_q    <= m_pq;
        m_r    <= m_pr;
      end
    end else if (Start) begin
      m_busy <= 1'b1;
      if (Divisor == 0) begin
        m_done <= 1'b1;
        m_q    <= 4'd15;
        m_r    <= Dividend;
        m_dz   <= 1'b1;
      end else begin
        m_left <= 4;
        m_dz   <= 1'b0;
        m_pq   <= Dividend / Divisor;
        m_pr   <= Dividend % Divisor;
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic run_job(input logic [3:0] a, input logic [3:0] d,
                         input int eq, input int er, input int edz, input int elat);
    int lat;
    bit seen;
    @(negedge Clock);
    Dividend = a;
    Divisor  = d;
    Start    = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
    lat   = 1;
    seen  = 1'b0;
    while (!seen && lat < 12) begin
      if (Done) seen = 1'b1;
      else begin
        @(negedge Clock);
        lat++;
      end
    end
    check($sformatf("latency_%0d_%0d", a, d), seen ? lat : -1, elat);
    check($sformatf("quot_%0d_%0d", a, d), Quotient, eq);
    check($sformatf("rem_%0d_%0d", a, d), Remainder, er);
    check($sformatf("dz_%0d_%0d", a, d), DivZero, edz);
  endtask

  initial begin
    int  dones;
    int  got_q, got_r;
    int  a, d, waited;
    bit  bad;

    fork
      forever begin
        @(negedge Clock);
        check("cycle_outputs",
              {Busy, Done, DivZero, Quotient, Remainder},
              {m_busy, m_done, m_dz, m_q, m_r});
      end
    join_none

    #1;
    check("reset_outputs", {Busy, Done, DivZero, Quotient, Remainder}, 0);
    repeat (2) @(negedge Clock);
    Resetn = 1'b1;

    run_job(4'd13, 4'd4, 3, 1, 0, 5);
    run_job(4'd15, 4'd1, 15, 0, 0, 5);
    run_job(4'd5, 4'd7, 0, 5, 0, 5);
    run_job(4'd15, 4'd15, 1, 0, 0, 5);
    run_job(4'd0, 4'd9, 0, 0, 0, 5);
    run_job(4'd8, 4'd3, 2, 2, 0, 5);

    run_job(4'd9, 4'd0, 15, 9, 1, 1);
    @(negedge Clock);
    check("div0_busy_one_cycle", Busy, 0);

    // A second Start mid-CALC with new operands must not disturb the job.
    @(negedge Clock);
    Dividend = 4'd12; Divisor = 4'd5; Start = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
    @(negedge Clock);
    Start = 1'b1; Dividend = 4'd15; Divisor = 4'd1;
    @(negedge Clock);
    Start = 1'b0;
    dones = 0; got_q = -1; got_r = -1;
    repeat (10) begin
      @(negedge Clock);
      if (Done) begin
        dones++;
        got_q = Quotient;
        got_r = Remainder;
      end
    end
    check("ignored_start_dones", dones, 1);
    check("ignored_start_quot", got_q, 2);
    check("ignored_start_rem", got_r, 2);

    // Asynchronous reset in the third CALC cycle aborts without a Done.
    @(negedge Clock);
    Dividend = 4'd13; Divisor = 4'd4; Start = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
    repeat (2) @(negedge Clock);
    #2 Resetn = 1'b0;
    #1;
    check("abort_outputs", {Busy, Done, DivZero, Quotient, Remainder}, 0);
    dones = 0;
    repeat (2) begin
      @(negedge Clock);
      if (Done) dones++;
    end
    Resetn = 1'b1;
    repeat (6) begin
      @(negedge Clock);
      if (Done) dones++;
    end
    check("abort_no_done", dones, 0);
    run_job(4'd10, 4'd3, 3, 1, 0, 5);

    // All 256 pairs back-to-back with Start held high.
    @(negedge Clock);
    Dividend = 4'd0; Divisor = 4'd0; Start = 1'b1;
    for (int idx = 0; idx < 256; idx++) begin
      a = idx / 16;
      d = idx % 16;
      waited = 0;
      do begin
        @(negedge Clock);
        waited++;
      end while (!Done && waited < 12);
      if (!Done) bad = 1'b1;
      else if (d == 0) bad = !(DivZero == 1'b1 && Quotient == 4'd15 && Remainder == a[3:0]);
      else bad = !(DivZero == 1'b0 && (Quotient * d + Remainder) == a && Remainder < d);
      checks++;
      if (bad) begin
        failures++;
        $display("FAIL exhaustive dividend=%0d divisor=%0d quot=%0d rem=%0d divzero=%0d done=%0d",
                 a, d, Quotient, Remainder, DivZero, Done);
        Start = 1'b0;
        break;
      end
      if (idx < 255) begin
        Dividend = 4'((idx + 1) / 16);
        Divisor  = 4'((idx + 1) % 16);
      end else begin
        Start = 1'b0;
      end
    end
    repeat (3) @(negedge Clock);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
